// File: rtl/bip_control.sv
// bip_control: fetch/execute sequencer and instruction decoder for the BIP core.
// Each instruction takes two clocks. FETCH is a wait cycle that covers the
// one-cycle PROGRAM_MEM read latency. EXEC decodes the opcode, drives the
// datapath strobes and bumps the PC.
//
// Optional feature: define BIP_CYCLE_COUNT_EN to get a saturating count of
// busy clocks on cycle_count. When it is undefined, cycle_count is tied to 0
// and the port list stays the same.
//
// state   | meaning
// --------+----------------------------------------------------------
// S_IDLE  | waiting for a start pulse
// S_FETCH | program memory read in flight, no controls asserted
// S_EXEC  | instr valid; decode drives datapath strobes and wr_pc
// S_HALT  | HLT retired; parked until reset, start ignored
module bip_control #(
  parameter int PC_LEN  = 16,
  parameter int INS_LEN = 16,
  parameter int CNT_LEN = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_LEN-1:0]  pc_in,
  input  logic [INS_LEN-1:0] instr,
  output logic               wr_pc,
  output logic [PC_LEN-1:0]  next_pc,
  output logic [10:0]        operand,
  output logic [1:0]         sel_a,
  output logic               sel_b,
  output logic               op,
  output logic               wr_acc,
  output logic               wr_ram,
  output logic               rd_ram,
  output logic               busy,
  output logic               halted,
  output logic [CNT_LEN-1:0] cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_FETCH = 2'b01,
    S_EXEC  = 2'b10,
    S_HALT  = 2'b11
  } state_t;

  localparam logic [4:0] OP_HLT  = 5'b00000;
  localparam logic [4:0] OP_STO  = 5'b00001;
  localparam logic [4:0] OP_LD   = 5'b00010;
  localparam logic [4:0] OP_LDI  = 5'b00011;
  localparam logic [4:0] OP_ADD  = 5'b00100;
  localparam logic [4:0] OP_ADDI = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  state_t     state_q, state_d;
  logic       busy_q, busy_d;
  logic       halted_q, halted_d;
  logic [4:0] opcode;

  assign opcode  = instr[INS_LEN-1 -: 5];
  assign next_pc = pc_in + {{(PC_LEN-1){1'b0}}, 1'b1};
  assign busy    = busy_q;
  assign halted  = halted_q;

  // Next-state logic; HLT is the only opcode that leaves the fetch/exec loop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = (opcode == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags are computed from the next state so that they line up with state_q.
  always_comb begin
    busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC);
    halted_d = (state_d == S_HALT);
  end

  // Registered FSM state and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      halted_q <= halted_d;
    end
  end

  // Instruction decode. It is only active in EXEC, so every strobe is zero in all other states.
  always_comb begin
    wr_pc   = 1'b0;
    operand = 11'd0;
    sel_a   = SEL_A_RAM;
    sel_b   = 1'b0;
    op      = 1'b0;
    wr_acc  = 1'b0;
    wr_ram  = 1'b0;
    rd_ram  = 1'b0;
    if (state_q == S_EXEC) begin
      operand = instr[10:0];
      wr_pc   = (opcode != OP_HLT);
      case (opcode)
        OP_STO: wr_ram = 1'b1;
        OP_LD: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SEL_A_RAM;
        end
        OP_LDI: begin
          wr_acc = 1'b1;
          sel_a  = SEL_A_IMM;
        end
        OP_ADD: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
        end
        OP_ADDI: begin
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b1;
        end
        OP_SUB: begin
          rd_ram = 1'b1;
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
          op     = 1'b1;
        end
        OP_SUBI: begin
          wr_acc = 1'b1;
          sel_a  = SEL_A_ALU;
          sel_b  = 1'b1;
          op     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef BIP_CYCLE_COUNT_EN
  logic [CNT_LEN-1:0] cycle_count_q, cycle_count_d;

  // Count the busy clocks and saturate at all-ones. The count freezes in HALT because busy is low there.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (busy_q && (cycle_count_q != {CNT_LEN{1'b1}}))
      cycle_count_d = cycle_count_q + {{(CNT_LEN-1){1'b0}}, 1'b1};
  end

  // Counter register; it is cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) cycle_count_q <= '0;
    else       cycle_count_q <= cycle_count_d;
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = '0;
`endif

endmodule

// File: tb/tb_bip_control.sv
// tb_bip_control: table-driven decode checks plus short programs run through a
// behavioural PC/PROGRAM_MEM model, compared through an expected-value queue.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        model_en = 1'b0;
  logic [15:0] pc_dir = 16'h0;
  logic [15:0] instr_dir = 16'h0;
  logic [15:0] pc_m = 16'h0;
  logic [15:0] instr_m = 16'h0;
  logic [15:0] pc_in, instr;
  logic [15:0] mem [16];

  logic        wr_pc, sel_b, op, wr_acc, wr_ram, rd_ram, busy, halted;
  logic [15:0] next_pc, cycle_count;
  logic [10:0] operand;
  logic [1:0]  sel_a;

  logic        c_wr_pc, c_sel_b, c_op, c_wr_acc, c_wr_ram, c_rd_ram, c_busy, c_halted;
  logic [15:0] c_next_pc;
  logic [10:0] c_operand;
  logic [1:0]  c_sel_a;
  logic [2:0]  c_cycle_count;

  always #5 clk = ~clk;

  assign pc_in = model_en ? pc_m : pc_dir;
  assign instr = model_en ? instr_m : instr_dir;

  // PC register and one-cycle-latency program memory.
  always @(posedge clk) begin
    if (reset) pc_m <= 16'h0;
    else if (wr_pc) pc_m <= next_pc;
    instr_m <= mem[pc_m[3:0]];
  end

  bip_control dut (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .instr(instr),
    .wr_pc(wr_pc), .next_pc(next_pc), .operand(operand), .sel_a(sel_a),
    .sel_b(sel_b), .op(op), .wr_acc(wr_acc), .wr_ram(wr_ram), .rd_ram(rd_ram),
    .busy(busy), .halted(halted), .cycle_count(cycle_count)
  );

  bip_control #(.CNT_LEN(3)) dut_c (
    .clk(clk), .reset(reset), .start(start), .pc_in(pc_in), .instr(instr),
    .wr_pc(c_wr_pc), .next_pc(c_next_pc), .operand(c_operand), .sel_a(c_sel_a),
    .sel_b(c_sel_b), .op(c_op), .wr_acc(c_wr_acc), .wr_ram(c_wr_ram), .rd_ram(c_rd_ram),
    .busy(c_busy), .halted(c_halted), .cycle_count(c_cycle_count)
  );

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        wr_pc;
    logic [1:0]  sel_a;
    logic        sel_b;
    logic        op;
    logic        wr_acc;
    logic        wr_ram;
    logic        rd_ram;
  } vec_t;

  vec_t vecs [10];
  logic [36:0] sbq [$];
  string       nq [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [36:0] pk(logic wpc, logic [15:0] npc, logic [10:0] opd,
                                     logic [1:0] sa, logic sb, logic o, logic wa,
                                     logic wr, logic rr, logic bz, logic hl);
    return {wpc, npc, opd, sa, sb, o, wa, wr, rr, bz, hl};
  endfunction

  function automatic logic [36:0] exp_idle(logic [15:0] pc);
    return pk(1'b0, pc + 16'd1, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [36:0] exp_fetch(logic [15:0] pc);
    return pk(1'b0, pc + 16'd1, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endfunction

  function automatic logic [36:0] exp_halt(logic [15:0] pc);
    return pk(1'b0, pc + 16'd1, 11'd0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  function automatic logic [36:0] exp_exec(vec_t v, logic [15:0] ins, logic [15:0] pc);
    return pk(v.wr_pc, pc + 16'd1, ins[10:0], v.sel_a, v.sel_b, v.op,
              v.wr_acc, v.wr_ram, v.rd_ram, 1'b1, 1'b0);
  endfunction

  function automatic int find_vec(logic [4:0] opc);
    for (int i = 0; i < 10; i++)
      if (vecs[i].instr[15:11] == opc) return i;
    return 0;
  endfunction

  task automatic push(string nm, logic [36:0] e);
    sbq.push_back(e);
    nq.push_back(nm);
  endtask

  task automatic check_pop();
    logic [36:0] act, e;
    string nm;
    act = pk(wr_pc, next_pc, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, busy, halted);
    n_cmp++;
    if (sbq.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: actual=%h required=<queued entry>", act);
    end else begin
      e = sbq.pop_front();
      nm = nq.pop_front();
      if (act !== e) begin
        n_err++;
        $display("FAIL %s: actual=%h required=%h (wr_pc,next_pc,operand,sel_a,sel_b,op,wr_acc,wr_ram,rd_ram,busy,halted)",
                 nm, act, e);
      end
    end
  endtask

  task automatic check_val(string nm, logic [31:0] act, logic [31:0] e);
    n_cmp++;
    if (act !== e) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, e);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Build the expected per-clock outputs from the program and then compare them clock by clock.
  task automatic run_prog(string nm, int n_cyc);
    logic [15:0] pc;
    logic        in_exec, hlt;
    logic [15:0] ins;
    model_en = 1'b1;
    do_reset();
    @(negedge clk);
    start = 1'b1;
    pc = 16'h0;
    in_exec = 1'b0;
    hlt = 1'b0;
    for (int c = 0; c < n_cyc; c++) begin
      if (hlt) push({nm, "_halt"}, exp_halt(pc));
      else if (!in_exec) begin
        push({nm, "_fetch"}, exp_fetch(pc));
        in_exec = 1'b1;
      end else begin
        ins = mem[pc[3:0]];
        push({nm, "_exec"}, exp_exec(vecs[find_vec(ins[15:11])], ins, pc));
        if (ins[15:11] == 5'b00000) hlt = 1'b1;
        else pc = pc + 16'd1;
        in_exec = 1'b0;
      end
    end
    @(negedge clk);
    start = 1'b0;
    check_pop();
    for (int c = 1; c < n_cyc; c++) begin
      @(negedge clk);
      check_pop();
    end
  endtask

  initial begin
    vecs[0] = '{16'h0000, 16'h0010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{16'h0802, 16'h0020, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{16'h1007, 16'h0030, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[3] = '{16'h1805, 16'h0040, 1'b1, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{16'h2003, 16'h0050, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{16'h2803, 16'h0060, 1'b1, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{16'h3004, 16'h0070, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[7] = '{16'h3FFF, 16'h0080, 1'b1, 2'b10, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[8] = '{16'h4000, 16'h1234, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{16'hF800, 16'hFFFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 16; i++) mem[i] = 16'h0000;

    // T1: reset, then idle with no start.
    model_en = 1'b0;
    pc_dir = 16'h0010;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      push("t1_idle", exp_idle(16'h0010));
      check_pop();
    end
    check_val("t1_cycle_count", 32'(cycle_count), 32'd0);

    // Decode table driven directly on pc_in/instr, including the pc wrap at FFFF.
    for (int i = 0; i < 10; i++) begin
      pc_dir = vecs[i].pc;
      instr_dir = vecs[i].instr;
      do_reset();
      @(negedge clk);
      start = 1'b1;
      push($sformatf("vec%0d_fetch", i), exp_fetch(vecs[i].pc));
      push($sformatf("vec%0d_exec", i), exp_exec(vecs[i], vecs[i].instr, vecs[i].pc));
      @(negedge clk);
      start = 1'b0;
      check_pop();
      @(negedge clk);
      check_pop();
    end

    // T2: LDI 5, ADDI 3, STO 2, HLT.
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0802; mem[3] = 16'h0000;
    run_prog("t2", 10);
`ifdef BIP_CYCLE_COUNT_EN
    check_val("t2_cycle_count", 32'(cycle_count), 32'd8);
`else
    check_val("t2_cycle_count", 32'(cycle_count), 32'd0);
`endif
    // A start pulse in HALT is ignored.
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 3; c++) push("t5_start_in_halt", exp_halt(16'h0003));
    @(negedge clk);
    start = 1'b0;
    check_pop();
    @(negedge clk); check_pop();
    @(negedge clk); check_pop();

    // T3: LD 7, SUB 7, HLT.
    mem[0] = 16'h1007; mem[1] = 16'h3007; mem[2] = 16'h0000; mem[3] = 16'h0000;
    run_prog("t3", 8);

    // T6: five NOPs then HLT; the 3-bit counter saturates at 7.
    for (int i = 0; i < 5; i++) mem[i] = 16'hF800;
    mem[5] = 16'h0000;
    run_prog("t6", 14);
`ifdef BIP_CYCLE_COUNT_EN
    check_val("t6_cycle_count16", 32'(cycle_count), 32'd12);
    check_val("t6_cycle_count3", 32'(c_cycle_count), 32'd7);
`else
    check_val("t6_cycle_count16", 32'(cycle_count), 32'd0);
    check_val("t6_cycle_count3", 32'(c_cycle_count), 32'd0);
`endif

    // T5: reset during EXEC of ADDI aborts back to IDLE.
    mem[0] = 16'h1805; mem[1] = 16'h2803; mem[2] = 16'h0802; mem[3] = 16'h0000;
    model_en = 1'b1;
    do_reset();
    @(negedge clk);
    start = 1'b1;
    push("t5_fetch0", exp_fetch(16'h0000));
    push("t5_ldi", exp_exec(vecs[3], 16'h1805, 16'h0000));
    push("t5_fetch1", exp_fetch(16'h0001));
    push("t5_addi", exp_exec(vecs[5], 16'h2803, 16'h0001));
    @(negedge clk);
    start = 1'b0;
    check_pop();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_pop();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    push("t5_after_reset", exp_idle(16'h0000));
    check_pop();
    check_val("t5_cycle_count", 32'(cycle_count), 32'd0);
    @(negedge clk);
    push("t5_idle", exp_idle(16'h0000));
    check_pop();

    check_val("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
